// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-fetch, datapath and next-PC control signals of the fetch sequencer
interface fetch_sequencer_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              exec_done;
  logic              zero_flag;
  logic [3:0]        pc_control;
  logic [25:0]       jump_address;
  logic [15:0]       branch_offset;
  logic [4:0]        reg_sel;
  logic              pc_update;
  logic              fetch_err;
  modport master (
    input  pc, imem_ack, imem_rdata, exec_done, zero_flag,
    output imem_req, imem_addr, instr, instr_valid, pc_control,
           jump_address, branch_offset, reg_sel, pc_update, fetch_err
  );
  modport slave (
    output pc, imem_ack, imem_rdata, exec_done, zero_flag,
    input  imem_req, imem_addr, instr, instr_valid, pc_control,
           jump_address, branch_offset, reg_sel, pc_update, fetch_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/decode/execute-wait/next-PC sequencer driving the PC control inputs.
// Define FETCH_TIMEOUT_EN to fault a fetch that sees no imem_ack within FETCH_TIMEOUT cycles.
module fetch_sequencer #(
  parameter int FETCH_TIMEOUT = 16,
  parameter int ADDR_W        = 32
) (
  input logic clk,
  input logic rst,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, UPDATE, HALT} state_t;
  typedef enum logic [2:0] {K_SEQ, K_J, K_JR, K_BEQ, K_BNE} kind_t;
  state_t state;
  kind_t  kind, kind_d;
  logic [3:0] ctl_d;
  if (FETCH_TIMEOUT < 1) begin : g_bad_timeout
    $error("FETCH_TIMEOUT must be at least 1");
  end
`ifdef FETCH_TIMEOUT_EN
  logic [$clog2(FETCH_TIMEOUT+1)-1:0] wait_cnt;
`endif
  always_comb begin
    kind_d = bus.instr[31:26] == 6'd2 ? K_J :
             (bus.instr[31:26] == 6'd0 && bus.instr[5:0] == 6'h08) ? K_JR :
             bus.instr[31:26] == 6'd4 ? K_BEQ :
             bus.instr[31:26] == 6'd5 ? K_BNE : K_SEQ;
    ctl_d  = kind == K_J  ? 4'b0001 :
             kind == K_JR ? 4'b0010 :
             ((kind == K_BEQ && bus.zero_flag) || (kind == K_BNE && !bus.zero_flag)) ? 4'b0011 : 4'b0000;
  end
  // In FETCH, imem_req low marks the entry cycle: pc is sampled there, after any PC update has landed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      kind               <= K_SEQ;
      bus.imem_req       <= 1'b0;
      bus.imem_addr      <= '0;
      bus.instr          <= '0;
      bus.instr_valid    <= 1'b0;
      bus.pc_control     <= 4'b0000;
      bus.jump_address   <= '0;
      bus.branch_offset  <= '0;
      bus.reg_sel        <= '0;
      bus.pc_update      <= 1'b0;
      bus.fetch_err      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt           <= '0;
`endif
    end else begin
      bus.instr_valid <= 1'b0;
      bus.pc_update   <= 1'b0;
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (!bus.imem_req) begin
            if (bus.pc[1:0] != 2'b00) begin
              bus.fetch_err  <= 1'b1;
              bus.pc_control <= 4'b1111;
              bus.pc_update  <= 1'b1;
              state          <= UPDATE;
            end else begin
              bus.imem_addr <= bus.pc;
              bus.imem_req  <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
              wait_cnt      <= '0;
`endif
            end
          end else if (bus.imem_ack) begin
            bus.instr       <= bus.imem_rdata;
            bus.imem_req    <= 1'b0;
            bus.instr_valid <= 1'b1;
            state           <= DECODE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (32'(wait_cnt) == FETCH_TIMEOUT - 1) begin
            bus.imem_req   <= 1'b0;
            bus.fetch_err  <= 1'b1;
            bus.pc_control <= 4'b1111;
            bus.pc_update  <= 1'b1;
            state          <= UPDATE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DECODE: begin
          kind  <= kind_d;
          state <= EXEC;
        end
        EXEC: begin
          if (bus.exec_done) begin
            bus.pc_control    <= ctl_d;
            bus.jump_address  <= bus.instr[25:0];
            bus.branch_offset <= bus.instr[15:0];
            bus.reg_sel       <= bus.instr[25:21];
            bus.pc_update     <= 1'b1;
            state             <= UPDATE;
          end
        end
        UPDATE: state <= bus.fetch_err ? HALT : FETCH;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
